stream_mux: RTL

Parametrised, registered N-channel, W-bit stream multiplexer; the handshaked successor of the combinational 16-bit 2:1 mux. It selects one of `CHANNELS` valid/ready input streams, either by an explicit select or by round-robin arbitration, and presents the chosen word on a single registered output stream. It sits between datapath producers (ALU result, memory read, I/O) and a shared consumer such as the register-file write port.

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/stream_mux.sv | 103 ++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared defaults and mode encodings for stream_mux.
// Holds the default geometry and the fixed/round-robin mode values.
package stream_mux_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int CHANNELS_DEF = 4;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin search over a request vector, starting at ptr+1.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     idx,
    output logic                any
);

    int c;

    // First requester after ptr, wrapping; ptr itself is checked last
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            c = (int'(ptr) + k) % CHANNELS;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = SELW'(c);
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: registered N-channel valid/ready stream multiplexer.
// Round-robin arbitration is built only when STREAM_MUX_RR_EN is defined.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic            free;
    logic            fixed_ok;
    logic            gnt;
    logic [SELW-1:0] g;
    logic            load;
    logic [WIDTH-1:0] word;

    assign free     = rst_n && (!out_valid || out_ready);
    assign fixed_ok = int'(sel) < CHANNELS;

`ifdef STREAM_MUX_RR_EN
    logic [SELW-1:0]     ptr;
    logic [CHANNELS-1:0] rr_grant;
    logic [SELW-1:0]     rr_idx;
    logic                rr_any;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // Pick the grant source from the current mode
    always_comb begin
        if (mode == MODE_RR) begin
            g   = rr_idx;
            gnt = rr_any;
        end else begin
            g   = sel;
            gnt = fixed_ok;
        end
    end

    // Pointer moves to the winner only on round-robin loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SELW'(CHANNELS - 1);
        end else if (load && mode == MODE_RR) begin
            ptr <= g;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign g           = sel;
    assign gnt         = fixed_ok;
`endif

    assign load = free && gnt && in_valid[g];
    assign word = in_data[int'(g)*WIDTH +: WIDTH];

    // Only the granted channel sees ready, and only when the register frees
    always_comb begin
        in_ready = '0;
        if (free && gnt) begin
            in_ready[g] = 1'b1;
        end
    end

    // One-entry output register: load, drain or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_chan  <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
